// File: rtl/usb3_tx_arbiter_if.sv
// Handshake and raw-word bundle between the OS/LP sources, the scrambler and usb3_tx_arbiter.
// The arbiter uses the slave modport; the sources and scrambler side use master.
interface usb3_tx_arbiter_if;
  logic        scr_mode;
  logic        os_req;
  logic [31:0] os_data;
  logic [3:0]  os_datak;
  logic        os_last;
  logic        os_grant;
  logic        lp_req;
  logic [31:0] lp_data;
  logic [3:0]  lp_datak;
  logic        lp_last;
  logic        lp_grant;
  logic        raw_stall;
  logic [31:0] raw_data;
  logic [3:0]  raw_datak;
  logic        raw_active;
  logic        scr_enable;

  modport master (
    output scr_mode, os_req, os_data, os_datak, os_last,
    output lp_req, lp_data, lp_datak, lp_last, raw_stall,
    input  os_grant, lp_grant, raw_data, raw_datak, raw_active, scr_enable
  );

  modport slave (
    input  scr_mode, os_req, os_data, os_datak, os_last,
    input  lp_req, lp_data, lp_datak, lp_last, raw_stall,
    output os_grant, lp_grant, raw_data, raw_datak, raw_active, scr_enable
  );
endinterface

// File: rtl/usb3_tx_arbiter.sv
// Packet-locked OS/LP arbiter feeding the USB3 scrambler, with burst-limited idle gaps.
// Define USB3_TX_ARB_RR_EN for round-robin between OS and LP; default is OS-over-LP priority.
module usb3_tx_arbiter #(
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned IDLE_GAP  = 2
) (
  input logic              local_clk,
  input logic              reset_n,
  usb3_tx_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOs   = 2'd1;
  localparam logic [1:0] StLp   = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [6:0]  burst_q, burst_d, burst_inc;
  logic [6:0]  gap_q, gap_d;
  logic        en_q, en_d;
  logic [31:0] raw_data_q, raw_data_d;
  logic [3:0]  raw_datak_q, raw_datak_d;
  logic        raw_active_q;
  logic        os_gnt, lp_gnt, xfer, sel_last, limit;

`ifdef USB3_TX_ARB_RR_EN
  logic rr_q, rr_d;  // 1: LP wins the next simultaneous contest
`endif

  always_comb begin
    os_gnt = 1'b0;
    lp_gnt = 1'b0;
    unique case (state_q)
      StIdle: begin
`ifdef USB3_TX_ARB_RR_EN
        if (bus.os_req && bus.lp_req) begin
          os_gnt = ~rr_q;
          lp_gnt = rr_q;
        end else begin
          os_gnt = bus.os_req;
          lp_gnt = bus.lp_req;
        end
`else
        os_gnt = bus.os_req;
        lp_gnt = bus.lp_req & ~bus.os_req;
`endif
      end
      StOs:    os_gnt = bus.os_req;
      StLp:    lp_gnt = bus.lp_req;
      default: ;
    endcase
    if (!reset_n) begin
      os_gnt = 1'b0;
      lp_gnt = 1'b0;
    end
  end

  assign bus.os_grant = os_gnt;
  assign bus.lp_grant = lp_gnt;

  assign xfer      = os_gnt | lp_gnt;
  assign sel_last  = os_gnt ? bus.os_last : bus.lp_last;
  assign burst_inc = (burst_q == 7'h7f) ? burst_q : burst_q + 7'd1;
  assign limit     = 32'(burst_inc) >= MAX_BURST;

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    if (xfer) burst_d = burst_inc;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (sel_last) state_d = limit ? StGap : StIdle;
          else          state_d = os_gnt ? StOs : StLp;
        end else begin
          burst_d = 7'd0;
        end
      end
      StOs, StLp: begin
        if (xfer && sel_last) state_d = limit ? StGap : StIdle;
      end
      default: begin
        gap_d = (gap_q == 7'd0) ? 7'd0 : gap_q - 7'd1;
        // Exit once the count reaches zero, unless the scrambler is still inserting SKP.
        if (gap_d == 7'd0 && !bus.raw_stall) begin
          state_d = StIdle;
          burst_d = 7'd0;
        end
      end
    endcase
    if (state_d == StGap && state_q != StGap) gap_d = 7'(IDLE_GAP);
  end

  always_comb begin
    en_d        = (state_q == StIdle && !xfer) ? bus.scr_mode : en_q;
    raw_data_d  = 32'd0;
    raw_datak_d = 4'd0;
    if (os_gnt) begin
      raw_data_d  = bus.os_data;
      raw_datak_d = bus.os_datak;
    end else if (lp_gnt) begin
      raw_data_d  = bus.lp_data;
      raw_datak_d = bus.lp_datak;
    end
  end

`ifdef USB3_TX_ARB_RR_EN
  assign rr_d = (xfer && sel_last) ? os_gnt : rr_q;

  always_ff @(posedge local_clk) begin
    if (!reset_n) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end
`endif

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      burst_q      <= 7'd0;
      gap_q        <= 7'd0;
      en_q         <= 1'b0;
      raw_data_q   <= 32'd0;
      raw_datak_q  <= 4'd0;
      raw_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      gap_q        <= gap_d;
      en_q         <= en_d;
      raw_data_q   <= raw_data_d;
      raw_datak_q  <= raw_datak_d;
      raw_active_q <= xfer;
    end
  end

  assign bus.raw_data   = raw_data_q;
  assign bus.raw_datak  = raw_datak_q;
  assign bus.raw_active = raw_active_q;
  assign bus.scr_enable = en_q;

endmodule

// File: tb/tb_usb3_tx_arbiter.sv
// Directed-vector bench for usb3_tx_arbiter (MAX_BURST=8, IDLE_GAP=2).
// Each cycle drives the sources, then checks grants and the registered raw outputs.
module tb_usb3_tx_arbiter;
  logic local_clk = 1'b0;
  logic reset_n   = 1'b0;
  int   n_chk     = 0;
  int   n_pass    = 0;
  logic rr_mode;

  usb3_tx_arbiter_if bus ();

  usb3_tx_arbiter #(
    .MAX_BURST(8),
    .IDLE_GAP (2)
  ) dut (
    .local_clk(local_clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 local_clk = ~local_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  // Drive one cycle of source inputs, then check grants and the outputs of the previous cycle.
  task automatic cyc(input string tag,
                     input logic osr, input logic [31:0] osd, input logic osl,
                     input logic lpr, input logic [31:0] lpd, input logic lpl,
                     input logic eog, input logic elg, input logic eact,
                     input logic [31:0] edat, input logic een);
    bus.os_req   = osr;
    bus.os_data  = osd;
    bus.os_datak = osd[3:0];
    bus.os_last  = osl;
    bus.lp_req   = lpr;
    bus.lp_data  = lpd;
    bus.lp_datak = lpd[3:0];
    bus.lp_last  = lpl;
    #1;
    check({tag, ".os_grant"}, 32'(bus.os_grant), 32'(eog));
    check({tag, ".lp_grant"}, 32'(bus.lp_grant), 32'(elg));
    check({tag, ".active"}, 32'(bus.raw_active), 32'(eact));
    check({tag, ".data"}, bus.raw_data, edat);
    check({tag, ".datak"}, 32'(bus.raw_datak), 32'(edat[3:0]));
    check({tag, ".scr_en"}, 32'(bus.scr_enable), 32'(een));
    tick();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    bus.os_req  = 1'b0;
    bus.lp_req  = 1'b0;
    bus.os_last = 1'b0;
    bus.lp_last = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  initial begin
`ifdef USB3_TX_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    bus.scr_mode  = 1'b0;
    bus.raw_stall = 1'b0;
    bus.os_data   = 32'd0;
    bus.os_datak  = 4'd0;
    bus.lp_data   = 32'd0;
    bus.lp_datak  = 4'd0;

    // Reset held with both requests high.
    bus.os_req  = 1'b1;
    bus.lp_req  = 1'b1;
    bus.os_last = 1'b1;
    bus.lp_last = 1'b1;
    repeat (3) tick();
    check("rst.os_grant", 32'(bus.os_grant), 32'd0);
    check("rst.lp_grant", 32'(bus.lp_grant), 32'd0);
    check("rst.active", 32'(bus.raw_active), 32'd0);
    check("rst.data", bus.raw_data, 32'd0);
    check("rst.datak", 32'(bus.raw_datak), 32'd0);
    check("rst.scr_en", 32'(bus.scr_enable), 32'd0);
    reset_n = 1'b1;
    cyc("rst_rel", 1, 32'hCAFE_0005, 1, 1, 32'hBEEF_0006, 1, 1, 0, 0, 32'd0, 0);
    cyc("rst_out", 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 1, 32'hCAFE_0005, 0);

    // Priority: OS 4 words, then LP 2 words, then two simultaneous single-word contests.
    do_reset();
    cyc("pri0", 1, 32'hA000_0001, 0, 1, 32'hB000_0001, 0, 1, 0, 0, 32'd0, 0);
    cyc("pri1", 1, 32'hA000_0002, 0, 1, 32'hB000_0001, 0, 1, 0, 1, 32'hA000_0001, 0);
    cyc("pri2", 1, 32'hA000_0003, 0, 1, 32'hB000_0001, 0, 1, 0, 1, 32'hA000_0002, 0);
    cyc("pri3", 1, 32'hA000_0004, 1, 1, 32'hB000_0001, 0, 1, 0, 1, 32'hA000_0003, 0);
    cyc("pri4", 0, 32'd0, 0, 1, 32'hB000_0001, 0, 0, 1, 1, 32'hA000_0004, 0);
    cyc("pri5", 0, 32'd0, 0, 1, 32'hB000_0002, 1, 0, 1, 1, 32'hB000_0001, 0);
    cyc("pri6", 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 1, 32'hB000_0002, 0);
    cyc("pri7", 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 0, 32'd0, 0);
    cyc("con0", 1, 32'hC000_0001, 1, 1, 32'hD000_0001, 1, 1, 0, 0, 32'd0, 0);
    cyc("con1", 1, 32'hC000_0002, 1, 1, 32'hD000_0001, 1, !rr_mode, rr_mode, 1,
        32'hC000_0001, 0);
    cyc("con2", 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 1,
        rr_mode ? 32'hD000_0001 : 32'hC000_0002, 0);

    // Forced gap: 10-word LP packet crosses the burst limit, then a 1-word packet.
    do_reset();
    for (int i = 0; i < 10; i++)
      cyc("gap_pkt", 0, 32'd0, 0, 1, 32'h1100_0000 + i, i == 9, 0, 1, i != 0,
          (i == 0) ? 32'd0 : 32'h1100_0000 + i - 1, 0);
    cyc("gap_g0", 0, 32'd0, 0, 1, 32'h2200_0007, 1, 0, 0, 1, 32'h1100_0009, 0);
    cyc("gap_g1", 0, 32'd0, 0, 1, 32'h2200_0007, 1, 0, 0, 0, 32'd0, 0);
    cyc("gap_go", 0, 32'd0, 0, 1, 32'h2200_0007, 1, 0, 1, 0, 32'd0, 0);
    cyc("gap_end", 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 1, 32'h2200_0007, 0);

    // Stall extension: 8-word packet hits the limit on its last word.
    do_reset();
    for (int i = 0; i < 8; i++)
      cyc("stl_pkt", 0, 32'd0, 0, 1, 32'h3300_0000 + i, i == 7, 0, 1, i != 0,
          (i == 0) ? 32'd0 : 32'h3300_0000 + i - 1, 0);
    cyc("stl_g0", 0, 32'd0, 0, 1, 32'h4400_0009, 1, 0, 0, 1, 32'h3300_0007, 0);
    bus.raw_stall = 1'b1;
    cyc("stl_g1", 0, 32'd0, 0, 1, 32'h4400_0009, 1, 0, 0, 0, 32'd0, 0);
    bus.raw_stall = 1'b0;
    cyc("stl_g2", 0, 32'd0, 0, 1, 32'h4400_0009, 1, 0, 0, 0, 32'd0, 0);
    cyc("stl_go", 0, 32'd0, 0, 1, 32'h4400_0009, 1, 0, 1, 0, 32'd0, 0);
    cyc("stl_end", 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 1, 32'h4400_0009, 0);

    // Enable sequencing: scr_mode rises during word 2 of a 5-word LP packet.
    do_reset();
    cyc("en0", 0, 32'd0, 0, 1, 32'h5500_0001, 0, 0, 1, 0, 32'd0, 0);
    bus.scr_mode = 1'b1;
    cyc("en1", 0, 32'd0, 0, 1, 32'h5500_0002, 0, 0, 1, 1, 32'h5500_0001, 0);
    cyc("en2", 0, 32'd0, 0, 1, 32'h5500_0003, 0, 0, 1, 1, 32'h5500_0002, 0);
    cyc("en3", 0, 32'd0, 0, 1, 32'h5500_0004, 0, 0, 1, 1, 32'h5500_0003, 0);
    cyc("en4", 0, 32'd0, 0, 1, 32'h5500_0005, 1, 0, 1, 1, 32'h5500_0004, 0);
    cyc("en5", 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 1, 32'h5500_0005, 0);
    cyc("en6", 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 0, 32'd0, 1);
    bus.scr_mode = 1'b0;

    // Source bubble: LP drops req for 3 cycles mid-packet while OS waits.
    do_reset();
    cyc("bub0", 0, 32'd0, 0, 1, 32'h6600_0001, 0, 0, 1, 0, 32'd0, 0);
    cyc("bub1", 0, 32'd0, 0, 1, 32'h6600_0002, 0, 0, 1, 1, 32'h6600_0001, 0);
    cyc("bub2", 1, 32'h7700_0001, 1, 0, 32'd0, 0, 0, 0, 1, 32'h6600_0002, 0);
    cyc("bub3", 1, 32'h7700_0001, 1, 0, 32'd0, 0, 0, 0, 0, 32'd0, 0);
    cyc("bub4", 1, 32'h7700_0001, 1, 0, 32'd0, 0, 0, 0, 0, 32'd0, 0);
    cyc("bub5", 1, 32'h7700_0001, 1, 1, 32'h6600_0003, 1, 0, 1, 0, 32'd0, 0);
    cyc("bub6", 1, 32'h7700_0001, 1, 0, 32'd0, 0, 1, 0, 1, 32'h6600_0003, 0);
    cyc("bub7", 0, 32'd0, 0, 0, 32'd0, 0, 0, 0, 1, 32'h7700_0001, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
